// File: rtl/uart_bus_master.sv
// uart_bus_master: autonomous initiator for the UART register block. It polls STATUS,
// drains a client TX FIFO into SEND and fills a client RX FIFO from RECV.
module uart_bus_master_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0] wr_ptr, rd_ptr;
  logic [7:0]  mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Extra pointer bit separates the wrapped-full case from empty.
  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

module uart_bus_master #(
  parameter int TX_DEPTH     = 4,
  parameter int RX_DEPTH     = 4,
  parameter int GUARD_CYCLES = 4
) (
  input  logic        clk_bus,
  input  logic        rst_n,
  input  logic        enable,
  output logic [3:0]  bus_address,
  output logic [31:0] bus_data_o,
  input  logic [31:0] bus_data_i,
  output logic        bus_read,
  output logic        bus_write,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready
);
  localparam logic [3:0] ADDR_SEND   = 4'h8;
  localparam logic [3:0] ADDR_RECV   = 4'h4;
  localparam logic [3:0] ADDR_STATUS = 4'hc;
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES - 1);
  localparam logic [GW-1:0] GUARD_ONE  = GW'(1);

  typedef enum logic [2:0] {IDLE, POLL, RD_RECV, WR_SEND, GUARD} state_t;
  typedef enum logic {OP_RX, OP_TX} op_t;

  state_t         state, state_nxt;
  op_t            last_op, last_op_nxt;
  logic [GW-1:0]  guard_cnt, guard_nxt;
  logic           tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0]     tx_head;
  logic           tx_push, tx_pop, rx_push, rx_pop;
  logic           rx_go, tx_go;
  logic           unused_bus_bits;

  assign tx_ready = !tx_full;
  assign rx_valid = !rx_empty;
  assign tx_push  = tx_valid && tx_ready;
  assign tx_pop   = (state == WR_SEND);
  assign rx_push  = (state == RD_RECV);
  assign rx_pop   = rx_valid && rx_ready;
  assign rx_go    = bus_data_i[1] && !rx_full;
  assign tx_go    = bus_data_i[0] && !tx_empty;
  assign unused_bus_bits = ^bus_data_i[31:8];

  uart_bus_master_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk_bus), .rst_n(rst_n), .push(tx_push), .push_data(tx_data),
    .pop(tx_pop), .head(tx_head), .full(tx_full), .empty(tx_empty)
  );

  uart_bus_master_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk_bus), .rst_n(rst_n), .push(rx_push), .push_data(bus_data_i[7:0]),
    .pop(rx_pop), .head(rx_data), .full(rx_full), .empty(rx_empty)
  );

  always_comb begin
    state_nxt   = state;
    last_op_nxt = last_op;
    guard_nxt   = guard_cnt;
    case (state)
      IDLE: if (enable) state_nxt = POLL;
      POLL: begin
        // Round robin only matters when both directions are ready at once.
        if (rx_go && tx_go)  state_nxt = (last_op == OP_RX) ? WR_SEND : RD_RECV;
        else if (rx_go)      state_nxt = RD_RECV;
        else if (tx_go)      state_nxt = WR_SEND;
        else if (!enable)    state_nxt = IDLE;
      end
      RD_RECV: begin
        state_nxt   = GUARD;
        last_op_nxt = OP_RX;
        guard_nxt   = GUARD_LOAD;
      end
      WR_SEND: begin
        state_nxt   = GUARD;
        last_op_nxt = OP_TX;
        guard_nxt   = GUARD_LOAD;
      end
      GUARD: begin
        // Gives the slave's flags time to cross back from the UART clock domain.
        if (guard_cnt == '0) state_nxt = enable ? POLL : IDLE;
        else                 guard_nxt = guard_cnt - GUARD_ONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so they appear registered.
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_op     <= OP_RX;
      guard_cnt   <= '0;
      bus_read    <= 1'b0;
      bus_write   <= 1'b0;
      bus_address <= '0;
      bus_data_o  <= '0;
    end else begin
      state      <= state_nxt;
      last_op    <= last_op_nxt;
      guard_cnt  <= guard_nxt;
      bus_read   <= (state_nxt == POLL) || (state_nxt == RD_RECV);
      bus_write  <= (state_nxt == WR_SEND);
      bus_data_o <= '0;
      case (state_nxt)
        POLL:    bus_address <= ADDR_STATUS;
        RD_RECV: bus_address <= ADDR_RECV;
        WR_SEND: begin
          bus_address <= ADDR_SEND;
          bus_data_o  <= {24'b0, tx_head};
        end
        default: bus_address <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_bus_master.sv
// Bench for uart_bus_master: behavioural UART slave, queue-based reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_uart_bus_master;
  localparam int TX_DEPTH = 4;
  localparam int RX_DEPTH = 4;
  localparam int GUARD_CYCLES = 4;
  localparam int K_NONE = 0, K_POLL = 1, K_RECV = 2, K_SEND = 3, K_BAD = 4;

  logic        clk = 1'b0;
  logic        rst_n, enable;
  logic [3:0]  bus_address;
  logic [31:0] bus_data_o, bus_data_i;
  logic        bus_read, bus_write;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;

  int n_checks = 0;
  int n_fail = 0;

  uart_bus_master #(.TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH), .GUARD_CYCLES(GUARD_CYCLES)) dut (
    .clk_bus(clk), .rst_n(rst_n), .enable(enable),
    .bus_address(bus_address), .bus_data_o(bus_data_o), .bus_data_i(bus_data_i),
    .bus_read(bus_read), .bus_write(bus_write),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  // UART slave: busy for 3 cycles after each SEND, RECV returns offered bytes in order.
  logic [7:0] slave_mem [0:31];
  int slave_total = 0;
  int slave_rd = 0;
  int tx_busy = 0;
  logic tx_idle_s, rx_avail_s;
  assign tx_idle_s  = (tx_busy == 0);
  assign rx_avail_s = (slave_rd < slave_total);

  always_comb begin
    bus_data_i = '0;
    if (bus_read) begin
      if (bus_address == 4'hc)      bus_data_i = {30'b0, rx_avail_s, tx_idle_s};
      else if (bus_address == 4'h4) bus_data_i = {24'b0, slave_mem[slave_rd[4:0]]};
    end
  end

  always @(posedge clk) begin
    if (bus_write)        tx_busy <= 3;
    else if (tx_busy > 0) tx_busy <= tx_busy - 1;
    if (bus_read && bus_address == 4'h4 && rx_avail_s) slave_rd <= slave_rd + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [7:0] send_log[$];
  int acc_log[$];
  int n_polls = 0;
  int n_recv = 0;

  initial begin
    int exp_kind, act, nxt, guard_left;
    bit last_tx, rxgo, txgo, tx_rdy_m, rx_vld_m;
    exp_kind = K_NONE; guard_left = 0; last_tx = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_kind = K_NONE; guard_left = 0; last_tx = 1'b0;
        txq.delete(); rxq.delete();
      end else begin
        if (bus_read && bus_write)                act = K_BAD;
        else if (bus_read && bus_address == 4'hc) act = K_POLL;
        else if (bus_read && bus_address == 4'h4) act = K_RECV;
        else if (bus_write && bus_address == 4'h8) act = K_SEND;
        else if (bus_read || bus_write)           act = K_BAD;
        else                                      act = K_NONE;
        tx_rdy_m = (txq.size() < TX_DEPTH);
        rx_vld_m = (rxq.size() > 0);
        check("bus_kind", act, exp_kind);
        check("tx_ready", 32'(tx_ready), 32'(tx_rdy_m));
        check("rx_valid", 32'(rx_valid), 32'(rx_vld_m));
        if (rx_vld_m) check("rx_data", 32'(rx_data), 32'(rxq[0]));

        nxt = K_NONE;
        case (exp_kind)
          K_POLL: begin
            rxgo = bus_data_i[1] && (rxq.size() < RX_DEPTH);
            txgo = bus_data_i[0] && (txq.size() > 0);
            if (rxgo && txgo) nxt = last_tx ? K_RECV : K_SEND;
            else if (rxgo)    nxt = K_RECV;
            else if (txgo)    nxt = K_SEND;
            else              nxt = enable ? K_POLL : K_NONE;
          end
          K_RECV, K_SEND: begin
            guard_left = GUARD_CYCLES;
            last_tx = (exp_kind == K_SEND);
          end
          default: begin
            if (guard_left > 0) begin
              guard_left--;
              if (guard_left == 0 && enable) nxt = K_POLL;
            end else if (enable) nxt = K_POLL;
          end
        endcase
        exp_kind = nxt;

        if (act == K_POLL) n_polls++;
        if (act == K_SEND) begin
          acc_log.push_back(K_SEND);
          send_log.push_back(bus_data_o[7:0]);
          check("send_queue_nonempty", 32'(txq.size() > 0), 32'd1);
          if (txq.size() > 0) begin
            check("send_data", bus_data_o, {24'b0, txq[0]});
            void'(txq.pop_front());
          end
        end
        if (rx_ready && rx_vld_m) void'(rxq.pop_front());
        if (act == K_RECV) begin
          acc_log.push_back(K_RECV);
          n_recv++;
          check("recv_has_space", 32'(rx_vld_m ? (rxq.size() + 1 <= RX_DEPTH) : 1'b1), 32'd1);
          rxq.push_back(bus_data_i[7:0]);
        end
        if (tx_valid && tx_rdy_m) txq.push_back(tx_data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    tx_data = b;
    tx_valid = 1'b1;
    while (!tx_ready && n < 100) begin step(); n++; end
    check("push_ready_timeout", 32'(tx_ready), 32'd1);
    step();
    tx_valid = 1'b0;
  endtask

  task automatic offer(input logic [7:0] b);
    slave_mem[slave_total[4:0]] = b;
    slave_total = slave_total + 1;
  endtask

  task automatic wait_write();
    int n = 0;
    while (!bus_write && n < 60) begin step(); n++; end
    check("wait_write_timeout", 32'(bus_write), 32'd1);
  endtask

  task automatic wait_sends(input int target);
    int n = 0;
    while (send_log.size() < target && n < 300) begin step(); n++; end
    check("send_count", send_log.size(), target);
  endtask

  initial begin
    int base, r0, p0, a0;
    int exp_seq [6];
    logic [7:0] exp_t6 [6];
    exp_seq = '{K_SEND, K_RECV, K_SEND, K_RECV, K_SEND, K_RECV};
    exp_t6  = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    rst_n = 1'b0; enable = 1'b0; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
    repeat (2) step();
    check("rst_bus_read", 32'(bus_read), 32'd0);
    check("rst_bus_write", 32'(bus_write), 32'd0);
    check("rst_bus_address", 32'(bus_address), 32'd0);
    check("rst_bus_data_o", bus_data_o, 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    rst_n = 1'b1;
    enable = 1'b1;

    // Three bytes sent in order, each behind a guard and a poll
    base = send_log.size();
    push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
    wait_sends(base + 3);
    check("t2_byte0", 32'(send_log[base]), 32'h41);
    check("t2_byte1", 32'(send_log[base+1]), 32'h42);
    check("t2_byte2", 32'(send_log[base+2]), 32'h43);
    repeat (6) step();

    // RX back-pressure: six bytes offered, only four fit
    r0 = n_recv;
    for (int i = 0; i < 3; i++) begin offer(8'h5A); offer(8'hA5); end
    repeat (60) step();
    check("t3_recv_when_full", n_recv - r0, 4);
    check("t3_rx_valid", 32'(rx_valid), 32'd1);
    check("t3_rx_head", 32'(rx_data), 32'h5A);
    rx_ready = 1'b1; step(); rx_ready = 1'b0;
    repeat (30) step();
    check("t3_recv_after_pop", n_recv - r0, 5);
    check("t3_rx_head_after_pop", 32'(rx_data), 32'hA5);
    rx_ready = 1'b1;
    repeat (40) step();
    check("t3_recv_total", n_recv - r0, 6);
    check("t3_drained", 32'(rx_valid), 32'd0);
    rx_ready = 1'b0;

    // Full TX FIFO, pop while client waits, then push and pop in one cycle
    enable = 1'b0;
    repeat (10) step();
    base = send_log.size();
    push_byte(8'h10); push_byte(8'h11); push_byte(8'h12); push_byte(8'h13);
    check("t6_full_ready", 32'(tx_ready), 32'd0);
    check("t6_model_count", txq.size(), 4);
    tx_data = 8'h14; tx_valid = 1'b1; enable = 1'b1;
    wait_write();
    check("t6_ready_during_pop", 32'(tx_ready), 32'd0);
    step();
    check("t6_ready_after_pop", 32'(tx_ready), 32'd1);
    step();
    check("t6_full_again", 32'(tx_ready), 32'd0);
    tx_valid = 1'b0;
    wait_write();
    step();
    wait_write();
    check("t6_ready_at_three", 32'(tx_ready), 32'd1);
    tx_data = 8'h15; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    check("t6_count_unchanged", txq.size(), 3);
    check("t6_ready_unchanged", 32'(tx_ready), 32'd1);
    wait_sends(base + 6);
    for (int i = 0; i < 6; i++) check("t6_order", 32'(send_log[base+i]), 32'(exp_t6[i]));

    // enable dropped during guard
    push_byte(8'h55);
    wait_write();
    step();
    enable = 1'b0;
    p0 = n_polls;
    repeat (12) step();
    check("t5_no_polls", n_polls - p0, 0);
    check("t5_last_send", 32'(send_log[send_log.size()-1]), 32'h55);
    enable = 1'b1;
    step();
    check("t5_poll_read", 32'(bus_read), 32'd1);
    check("t5_poll_addr", 32'(bus_address), 32'hc);

    // Reset while a SEND is on the bus
    push_byte(8'h77);
    wait_write();
    base = send_log.size();
    #2 rst_n = 1'b0;
    #1;
    check("t1_write_dropped", 32'(bus_write), 32'd0);
    check("t1_read_low", 32'(bus_read), 32'd0);
    check("t1_addr_zero", 32'(bus_address), 32'd0);
    check("t1_tx_ready", 32'(tx_ready), 32'd1);
    step();
    rst_n = 1'b1;
    repeat (20) step();
    check("t1_no_replay", send_log.size(), base);

    // Both directions ready: strict alternation starting with SEND
    enable = 1'b0;
    repeat (10) step();
    push_byte(8'h31); push_byte(8'h32); push_byte(8'h33);
    offer(8'hC1); offer(8'hC2); offer(8'hC3);
    rx_ready = 1'b1;
    a0 = acc_log.size();
    base = send_log.size();
    enable = 1'b1;
    repeat (60) step();
    check("t4_access_count", acc_log.size() - a0, 6);
    for (int i = 0; i < 6; i++)
      if (a0 + i < acc_log.size()) check("t4_alternation", acc_log[a0+i], exp_seq[i]);
    check("t4_send_first", 32'(send_log[base]), 32'h31);
    check("t4_rx_drained", 32'(rx_valid), 32'd0);
    rx_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
